sram_cdt_master: RTL and testbench
==================================

Name: sram_cdt_master

Overview:
- Initiator for the SRAM conduit (cdt) interface consumed by the Platform Designer system's SRAM path.
- Turns a simple valid/ready request port (read/write, address, data, byte enables) into timed conduit cycles: write, chipselect, outputenable, address, byteenable and bidirectional data_io.
- Returns read data with a single-cycle rvalid strobe.
- Used by fabric logic (pixel writer, test pattern generator) that fills or inspects the frame buffer in external SRAM.

Parameters:
- ADDR_W, 20, conduit address width
- DATA_W, 16, conduit data width
- SETUP_CYCLES, 1, cycles with address/chipselect stable before the strobe; legal range 1..15
- ACCESS_CYCLES, 2, strobe cycles (write high, or read sampling window); legal range 1..15
- HOLD_CYCLES, 1, cycles after the strobe with chipselect/address/data held; legal range 0..15

Ports:
- clk_clk  in  1  system clock
- reset_reset  in  1  asynchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_write  in  1  1=write, 0=read
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  write data
- req_be  in  2  byte enables, bit0=low byte
- rsp_valid  out  1  one-cycle strobe, rsp_rdata valid
- rsp_rdata  out  DATA_W  read data
- cdt_write  out  1  conduit write strobe
- cdt_chipselect  out  1  conduit chip select
- cdt_outputenable  out  1  conduit output enable
- cdt_address  out  ADDR_W  conduit address
- cdt_byteenable  out  2  conduit byte enables
- cdt_data_io  inout  DATA_W  conduit data, driven only during write transactions

Behaviour:
- One clock domain, clk_clk. Reset is asynchronous and active-high on reset_reset.
- Reset values:
  - req_ready=1; rsp_valid=0; rsp_rdata=0.
  - All cdt_* control outputs 0; cdt_address=0; cdt_byteenable=0.
  - cdt_data_io high-Z.
  - FSM in IDLE.
- FSM states: IDLE, SETUP, ACCESS, HOLD.
  - req_ready=1 only in IDLE.
  - IDLE: on req_valid&req_ready at edge T, latch write/addr/wdata/be, go to SETUP. SETUP occupies cycle T+1.
  - SETUP: lasts SETUP_CYCLES, then ACCESS.
  - ACCESS: lasts ACCESS_CYCLES, then HOLD; goes straight to IDLE if HOLD_CYCLES=0.
  - HOLD: lasts HOLD_CYCLES, then IDLE.
- One down-counter (4 bits) is reloaded at each state entry.
- cdt_chipselect, cdt_address and cdt_byteenable are driven from the latched values in SETUP, ACCESS and HOLD. They are 0 in IDLE.
- Write transaction:
  - cdt_write=1 only in ACCESS.
  - cdt_data_io driven with latched wdata in SETUP, ACCESS and HOLD.
  - cdt_outputenable=0 throughout.
- Read transaction:
  - cdt_outputenable=1 in SETUP and ACCESS; 0 in HOLD.
  - cdt_data_io high-Z throughout.
  - rsp_rdata is captured from cdt_data_io at the clock edge ending the last ACCESS cycle.
  - rsp_valid=1 for exactly the next cycle (first HOLD cycle, or the IDLE cycle if HOLD_CYCLES=0).
  - rsp_rdata holds its value until the next read capture.
- All cdt_* outputs and the data tristate enable are registered (no combinational path from req_* to cdt_*).
- Transaction length = SETUP_CYCLES+ACCESS_CYCLES+HOLD_CYCLES. Defaults give 4 cycles.
- Minimum one IDLE cycle between transactions. Back-to-back throughput is one transaction per (length+1) cycles.
- req_* inputs are ignored while req_ready=0. A request held valid across busy cycles is accepted in the first IDLE cycle.
- req_be=2'b00 still executes a full bus cycle, with byteenable=00.
- Reset mid-transaction takes effect immediately:
  - all cdt_* outputs go to 0 and data_io goes high-Z;
  - the transaction is dropped and no rsp_valid is issued;
  - req_ready=1 once reset is released.

Test Plan:
- Write at default parameters: write addr 0x12345, data 0xBEEF, be 11, accepted at edge T.
  - chipselect=1 in cycles T+1..T+4; write=1 in T+2..T+3.
  - data_io=0xBEEF in T+1..T+4; address=0x12345 in T+1..T+4.
  - req_ready=0 in T+1..T+4, 1 in T+5.
- Read: responder model drives 0xA5C3 while outputenable=1; read addr 0x00010 accepted at T.
  - outputenable=1 in T+1..T+3.
  - rsp_valid=1 only in T+4, with rsp_rdata=0xA5C3.
  - data_io never driven by the DUT.
- Byte write: be=01, data 0x00FF at addr 0xFFFFF.
  - byteenable=01 in T+1..T+4; address=0xFFFFF (top address, no wrap).
- Busy request: assert a second request (read 0x00002) during the ACCESS cycles of a write.
  - Second request is ignored until IDLE, accepted at T+5, and its chipselect starts at T+6.
- Reset mid-operation: assert reset in the second ACCESS cycle of a write.
  - Same cycle: write=0, chipselect=0, data_io=Z.
  - After release, req_ready=1 and no rsp_valid is seen.
- Parameter sweep: SETUP=2, ACCESS=1, HOLD=0, read.
  - outputenable=1 in T+1..T+3; rsp_valid in T+4; req_ready=1 in T+4.

Source files
------------

// File: rtl/sram_cdt_master.sv
// Initiator for the SRAM conduit: converts a valid/ready request into timed
// chipselect / strobe / output-enable cycles and returns read data with a strobe.
module sram_cdt_master #(
    parameter int ADDR_W        = 20,
    parameter int DATA_W        = 16,
    parameter int SETUP_CYCLES  = 1,
    parameter int ACCESS_CYCLES = 2,
    parameter int HOLD_CYCLES   = 1
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [1:0]        req_be,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              cdt_write,
    output logic              cdt_chipselect,
    output logic              cdt_outputenable,
    output logic [ADDR_W-1:0] cdt_address,
    output logic [1:0]        cdt_byteenable,
    inout  wire  [DATA_W-1:0] cdt_data_io
);
    // Handshake: a request transfers on a clock edge where req_valid and
    // req_ready are both high; req_ready is high only while idle.
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

    localparam logic [3:0] SETUP_LOAD  = 4'(SETUP_CYCLES - 1);
    localparam logic [3:0] ACCESS_LOAD = 4'(ACCESS_CYCLES - 1);
    localparam logic [3:0] HOLD_LOAD   = (HOLD_CYCLES > 0) ? 4'(HOLD_CYCLES - 1) : 4'd0;

    state_t            state, state_next;
    logic [3:0]        cnt, cnt_next;
    logic              lat_write;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [1:0]        lat_be;
    logic              drive_en;

    logic              accept, capture, busy_n, write_n;
    logic [ADDR_W-1:0] addr_n;
    logic [1:0]        be_n;

    assign req_ready   = (state == IDLE);
    assign accept      = req_valid && req_ready;
    assign capture     = (state == ACCESS) && (cnt == 4'd0) && !lat_write;
    assign cdt_data_io = drive_en ? lat_wdata : {DATA_W{1'bz}};

    always_comb begin
        state_next = state;
        cnt_next   = cnt - 4'd1;
        case (state)
            IDLE: begin
                cnt_next = cnt;
                if (accept) begin
                    state_next = SETUP;
                    cnt_next   = SETUP_LOAD;
                end
            end
            SETUP: if (cnt == 4'd0) begin
                state_next = ACCESS;
                cnt_next   = ACCESS_LOAD;
            end
            ACCESS: if (cnt == 4'd0) begin
                state_next = (HOLD_CYCLES == 0) ? IDLE : HOLD;
                cnt_next   = HOLD_LOAD;
            end
            HOLD: if (cnt == 4'd0) begin
                state_next = IDLE;
                cnt_next   = 4'd0;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    // Conduit outputs are registered from the values the next cycle will see.
    always_comb begin
        busy_n  = (state_next != IDLE);
        write_n = accept ? req_write : lat_write;
        addr_n  = busy_n ? (accept ? req_addr : lat_addr) : '0;
        be_n    = busy_n ? (accept ? req_be : lat_be) : 2'b00;
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state            <= IDLE;
            cnt              <= 4'd0;
            lat_write        <= 1'b0;
            lat_addr         <= '0;
            lat_wdata        <= '0;
            lat_be           <= 2'b00;
            drive_en         <= 1'b0;
            cdt_write        <= 1'b0;
            cdt_chipselect   <= 1'b0;
            cdt_outputenable <= 1'b0;
            cdt_address      <= '0;
            cdt_byteenable   <= 2'b00;
            rsp_valid        <= 1'b0;
            rsp_rdata        <= '0;
        end else begin
            state            <= state_next;
            cnt              <= cnt_next;
            if (accept) begin
                lat_write <= req_write;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                lat_be    <= req_be;
            end
            drive_en         <= write_n && busy_n;
            cdt_write        <= write_n && (state_next == ACCESS);
            cdt_chipselect   <= busy_n;
            cdt_outputenable <= !write_n && ((state_next == SETUP) || (state_next == ACCESS));
            cdt_address      <= addr_n;
            cdt_byteenable   <= be_n;
            rsp_valid        <= capture;
            if (capture) rsp_rdata <= cdt_data_io;
        end
    end
endmodule

// File: tb/tb_sram_cdt_master.sv
// Bench for sram_cdt_master: default and swept-parameter instances, checked
// cycle by cycle against a phase-offset model of the conduit timing.
module tb_sram_cdt_master;
    typedef struct packed {
        logic        rdy;
        logic        rv;
        logic        wr;
        logic        cs;
        logic        oe;
        logic [15:0] rdata;
        logic [19:0] addr;
        logic [1:0]  be;
        logic [15:0] bus;
    } obs_t;

    int S_P[2] = '{1, 2};
    int A_P[2] = '{2, 1};
    int H_P[2] = '{1, 0};

    logic        clk, rst;
    logic        req_valid[2], req_write[2];
    logic [19:0] req_addr[2];
    logic [15:0] req_wdata[2], resp_data[2], last_rdata[2];
    logic [1:0]  req_be[2];
    logic [15:0] exp_q[$];
    int          n_tests = 0, n_fail = 0;

    wire        rdy0, rv0, wr0, cs0, oe0, rdy1, rv1, wr1, cs1, oe1;
    wire [15:0] rdata0, rdata1, bus0, bus1;
    wire [19:0] addr0, addr1;
    wire [1:0]  be0, be1;

    // Responder: drives the bus only while the conduit asks for read data.
    assign bus0 = oe0 ? resp_data[0] : 16'bz;
    assign bus1 = oe1 ? resp_data[1] : 16'bz;

    sram_cdt_master dut0 (
        .clk_clk(clk), .reset_reset(rst),
        .req_valid(req_valid[0]), .req_ready(rdy0), .req_write(req_write[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
        .rsp_valid(rv0), .rsp_rdata(rdata0),
        .cdt_write(wr0), .cdt_chipselect(cs0), .cdt_outputenable(oe0),
        .cdt_address(addr0), .cdt_byteenable(be0), .cdt_data_io(bus0)
    );

    sram_cdt_master #(.SETUP_CYCLES(2), .ACCESS_CYCLES(1), .HOLD_CYCLES(0)) dut1 (
        .clk_clk(clk), .reset_reset(rst),
        .req_valid(req_valid[1]), .req_ready(rdy1), .req_write(req_write[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
        .rsp_valid(rv1), .rsp_rdata(rdata1),
        .cdt_write(wr1), .cdt_chipselect(cs1), .cdt_outputenable(oe1),
        .cdt_address(addr1), .cdt_byteenable(be1), .cdt_data_io(bus1)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic obs_t get_obs(input int i);
        obs_t o;
        if (i == 0) o = '{rdy0, rv0, wr0, cs0, oe0, rdata0, addr0, be0, bus0};
        else        o = '{rdy1, rv1, wr1, cs1, oe1, rdata1, addr1, be1, bus1};
        return o;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input int i);
        obs_t o = get_obs(i);
        check("idle_ready", o.rdy, 1'b1);
        check("idle_rsp_valid", o.rv, 1'b0);
        check("idle_rdata", o.rdata, last_rdata[i]);
        check("idle_cs", o.cs, 1'b0);
        check("idle_wr", o.wr, 1'b0);
        check("idle_oe", o.oe, 1'b0);
        check("idle_addr", o.addr, 20'h0);
        check("idle_be", o.be, 2'b00);
        check("idle_bus", o.bus, 16'hzzzz);
    endtask

    // Driver + per-cycle check of one transaction. Called at a negedge; returns
    // at the negedge of the first idle cycle after the transaction.
    task automatic do_txn(input int i, input bit w, input logic [19:0] a, input logic [15:0] d,
                          input logic [1:0] be, input logic [15:0] rd,
                          input bit chain, input logic [19:0] nxt_a);
        int s = S_P[i];
        int ac = A_P[i];
        int len = S_P[i] + A_P[i] + H_P[i];
        int waited = 0;
        bit busy, acc, rsp;
        logic [15:0] exp_bus, exp_rd;
        obs_t o;
        req_valid[i] = 1'b1; req_write[i] = w; req_addr[i] = a;
        req_wdata[i] = d;    req_be[i] = be;
        if (!w) begin
            resp_data[i] = rd;
            exp_q.push_back(rd);
        end
        while (!get_obs(i).rdy && waited < 32) begin
            @(negedge clk);
            waited++;
        end
        check("accept_wait_bound", waited >= 32, 1'b0);
        if (waited >= 32) return;
        @(negedge clk);
        for (int k = 1; k <= len + 1; k++) begin
            o = get_obs(i);
            busy = (k <= len);
            acc  = (k > s) && (k <= s + ac);
            rsp  = !w && (k == s + ac + 1);
            exp_bus = (w && busy) ? d : ((!w && k <= s + ac) ? rd : 16'hzzzz);
            check("req_ready", o.rdy, !busy);
            check("chipselect", o.cs, busy);
            check("write", o.wr, w && acc);
            check("outputenable", o.oe, !w && (k <= s + ac));
            check("address", o.addr, busy ? a : 20'h0);
            check("byteenable", o.be, busy ? be : 2'b00);
            check("data_io", o.bus, exp_bus);
            check("rsp_valid", o.rv, rsp);
            if (rsp) begin
                exp_rd = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
                last_rdata[i] = exp_rd;
            end
            check("rsp_rdata", o.rdata, last_rdata[i]);
            if (k == len + 1) break;
            if (chain) begin
                if (k == s + 1) begin
                    req_valid[i] = 1'b1; req_write[i] = 1'b0; req_addr[i] = nxt_a;
                    req_wdata[i] = 16'h0; req_be[i] = 2'b11;
                end else if (k < s + 1) begin
                    req_valid[i] = 1'b0;
                end
            end else if (k < len) begin
                req_valid[i] = 1'($urandom_range(0, 1)); req_write[i] = 1'($urandom);
                req_addr[i] = 20'($urandom); req_wdata[i] = 16'($urandom);
                req_be[i] = 2'($urandom);
            end else begin
                req_valid[i] = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic reset_mid_write();
        obs_t o;
        int waited = 0;
        req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 20'h0ABCD;
        req_wdata[0] = 16'h1357; req_be[0] = 2'b11;
        while (!get_obs(0).rdy && waited < 32) begin
            @(negedge clk);
            waited++;
        end
        check("rst_accept_wait_bound", waited >= 32, 1'b0);
        @(negedge clk);
        req_valid[0] = 1'b0;
        repeat (2) @(negedge clk);
        o = get_obs(0);
        check("rst_pre_write", o.wr, 1'b1);
        rst = 1'b1;
        #1;
        o = get_obs(0);
        check("rst_write", o.wr, 1'b0);
        check("rst_chipselect", o.cs, 1'b0);
        check("rst_data_io", o.bus, 16'hzzzz);
        check("rst_address", o.addr, 20'h0);
        last_rdata[0] = 16'h0;
        last_rdata[1] = 16'h0;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check_idle(0);
            check_idle(1);
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0; req_write[i] = 1'b0; req_addr[i] = 20'h0;
            req_wdata[i] = 16'h0; req_be[i] = 2'b00; resp_data[i] = 16'h0;
            last_rdata[i] = 16'h0;
        end
        repeat (2) @(negedge clk);
        check_idle(0);
        check_idle(1);
        rst = 1'b0;
        @(negedge clk);

        do_txn(0, 1'b1, 20'h12345, 16'hBEEF, 2'b11, 16'h0, 1'b0, 20'h0);
        do_txn(0, 1'b0, 20'h00010, 16'h0, 2'b11, 16'hA5C3, 1'b0, 20'h0);
        do_txn(0, 1'b1, 20'hFFFFF, 16'h00FF, 2'b01, 16'h0, 1'b0, 20'h0);
        do_txn(0, 1'b1, 20'h00400, 16'h4321, 2'b11, 16'h0, 1'b1, 20'h00002);
        do_txn(0, 1'b0, 20'h00002, 16'h0, 2'b11, 16'h6E6E, 1'b0, 20'h0);
        do_txn(0, 1'b1, 20'h00777, 16'hCAFE, 2'b00, 16'h0, 1'b0, 20'h0);
        do_txn(1, 1'b0, 20'h00123, 16'h0, 2'b11, 16'h3C3C, 1'b0, 20'h0);
        do_txn(1, 1'b1, 20'h00456, 16'h9876, 2'b10, 16'h0, 1'b0, 20'h0);
        reset_mid_write();

        for (int n = 0; n < 40; n++) begin
            do_txn($urandom_range(0, 1), 1'($urandom), 20'($urandom), 16'($urandom),
                   2'($urandom), 16'($urandom), 1'b0, 20'h0);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        check("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
